cmem_fill: RTL and testbench
============================

Name: cmem_fill

Overview:
- Responder end of the shared-cache external line-fill bus (block address / read strobe / line data / data-valid).
- Accepts one cache-line read request at a time.
- Fetches the line from main memory as a sequence of WORD_W-bit beats over a simple request/acknowledge memory port.
- Assembles the beats into a full line and returns it with a single-cycle data-valid pulse.
- Sits between the shared cache and the memory/interconnect.

Parameters:
- BLK_LEN, 58, width of the block (line) address on the cache side.
- LINE_W, 512, cache line width in bits; must be a multiple of WORD_W.
- WORD_W, 64, memory beat width in bits.
- ADDR_W, 64, memory byte-address width.
- BEATS, LINE_W/WORD_W (derived), beats per line; must be at least 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- b_addr_c  in  BLK_LEN  block address of the requested line.
- b_rd_c  in  1  line read request, held high by the cache until b_dv_c.
- b_rdata_c  out  LINE_W  assembled line; beat 0 occupies bits [WORD_W-1:0].
- b_dv_c  out  1  one-cycle pulse: b_rdata_c valid.
- m_addr  out  ADDR_W  byte address of the current beat.
- m_rd  out  1  memory beat read request.
- m_rdata  in  WORD_W  beat data, valid when m_ack.
- m_ack  in  1  beat acknowledge, one cycle per beat.

Behaviour:
- Reset (async, rst=1): state IDLE; b_dv_c=0, m_rd=0, m_addr=0, b_rdata_c=0, beat counter=0, abort flag=0. Asserting reset mid-fetch drops m_rd immediately; the memory model must tolerate this.
- States: IDLE, FETCH, DONE.
- IDLE, b_rd_c=1:
  - latch b_addr_c into blk_q; counter=0; abort=0; go to FETCH.
  - b_addr_c is ignored after acceptance.
- FETCH:
  - m_rd=1, m_addr = zero-extend/truncate to ADDR_W of {blk_q, cnt, log2(WORD_W/8) zero bits}.
  - m_rd and m_addr stay constant until m_ack.
  - On m_ack: write m_rdata into b_rdata_c[cnt*WORD_W +: WORD_W] and increment cnt. Next cycle m_rd stays high with the next address (back-to-back beats allowed).
  - On m_ack with cnt==BEATS-1: go to DONE if abort=0, else to IDLE. m_rd=0 from the next cycle.
- DONE: b_dv_c=1 for exactly one cycle, then IDLE.
  - b_rdata_c holds its value from the DONE cycle until the first beat of the next accepted request.
  - An IDLE request in the cycle after DONE is accepted normally. The cache normally has b_rd_c=0 in that cycle.
- Abort: b_rd_c=0 in any FETCH cycle sets abort.
  - The remaining beats are still fetched (memory handshake is never broken), data is written, and no b_dv_c is issued.
  - b_rd_c falling in the same cycle as the last m_ack also aborts (no dv).
  - b_rd_c re-rising during an aborted fetch does not clear abort. The request is re-accepted from IDLE after the drain completes.
- Latency: with zero-wait memory (m_ack in the first m_rd cycle), an accept at cycle T gives m_rd at T+1..T+BEATS and b_dv_c at T+BEATS+1.
- Counter width is clog2(BEATS); it never wraps within a line. m_ack while m_rd=0 is ignored.

Decomposition:
- Shared package (config header): state encodings (CF_S_IDLE, CF_S_FETCH, CF_S_DONE), BEATS and byte-offset width derivations, default LINE_W/WORD_W consistent with the cache line config.
- One natural sub-module, cmem_fill_buf: the LINE_W line register with per-beat write enable indexed by cnt. The FSM and address generation stay in cmem_fill.

Test Plan:
- Reset during FETCH at beat 3 -> m_rd=0 and b_dv_c=0 in the same cycle. With rst then low, state is IDLE, b_rdata_c=0, and the next request starts at beat 0.
- b_addr_c=0x1, b_rd_c held, zero-wait memory returning word i = 0x1000+i:
  - m_addr 0x40,0x48,...,0x78 on consecutive cycles;
  - b_dv_c pulses once at T+9;
  - b_rdata_c[63:0]=0x1000 and b_rdata_c[511:448]=0x1007.
- Memory with 3-cycle ack delay per beat -> m_addr stable for 3 cycles per beat; b_dv_c at T+8*3+1; single pulse.
- b_rd_c dropped after beat 2 ack -> remaining 5 beats still requested (m_addr up to 0x78); no b_dv_c; IDLE afterwards.
- b_rd_c dropped exactly with the last m_ack -> no b_dv_c. Request 0x2 issued next cycle -> m_addr 0x80 and a normal completion.
- Back-to-back: request 0x3 completes, b_rd_c re-raised with 0x4 in the cycle after DONE -> accepted; m_addr 0x100 next cycle; b_rdata_c keeps line 0x3 until the first beat of 0x4.

Source files
------------

// File: rtl/cmem_fill_pkg.sv
// Shared configuration for the cache line-fill responder: FSM state encodings,
// default line/beat geometry and the width derivations used by the fill logic.
package cmem_fill_pkg;

  localparam int CF_BLK_LEN = 58;
  localparam int CF_LINE_W  = 512;
  localparam int CF_WORD_W  = 64;
  localparam int CF_ADDR_W  = 64;

  typedef enum logic [1:0] {
    CF_S_IDLE  = 2'd0,
    CF_S_FETCH = 2'd1,
    CF_S_DONE  = 2'd2
  } cf_state_t;

  // Number of memory beats that make up one cache line.
  function automatic int cf_beats(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  // Number of byte-offset bits covered by one beat.
  function automatic int cf_off_w(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  // Width of the beat counter within a line.
  function automatic int cf_cnt_w(input int beats);
    return $clog2(beats);
  endfunction

  localparam int CF_BEATS = cf_beats(CF_LINE_W, CF_WORD_W);

endpackage

// File: rtl/cmem_fill_buf.sv
// Line assembly register: collects memory beats into one cache line, with the
// beat slot selected by the fill counter. Beat 0 lands in the low word.
module cmem_fill_buf
  import cmem_fill_pkg::*;
#(
  parameter int LINE_W = CF_LINE_W,
  parameter int WORD_W = CF_WORD_W
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           we,
  input  logic [cf_cnt_w(cf_beats(LINE_W, WORD_W))-1:0]  idx,
  input  logic [WORD_W-1:0]                              wdata,
  output logic [LINE_W-1:0]                              line
);

  localparam int BEATS = cf_beats(LINE_W, WORD_W);
  localparam int CNT_W = cf_cnt_w(BEATS);

  // Write the incoming beat into its slot; other slots keep their contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line <= '0;
    end else if (we) begin
      for (int b = 0; b < BEATS; b++) begin
        if (idx == CNT_W'(b)) begin
          line[b*WORD_W +: WORD_W] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/cmem_fill.sv
// Line-fill responder for the shared cache: accepts one block read, fetches it
// beat by beat over the memory request/acknowledge port and returns the whole
// line with a one-cycle data-valid pulse. A request withdrawn mid-fetch still
// drains all beats so the memory handshake is never broken, but gives no pulse.
module cmem_fill
  import cmem_fill_pkg::*;
#(
  parameter int BLK_LEN = CF_BLK_LEN,
  parameter int LINE_W  = CF_LINE_W,
  parameter int WORD_W  = CF_WORD_W,
  parameter int ADDR_W  = CF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_LEN-1:0] b_addr_c,
  input  logic               b_rd_c,
  output logic [LINE_W-1:0]  b_rdata_c,
  output logic               b_dv_c,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_rd,
  input  logic [WORD_W-1:0]  m_rdata,
  input  logic               m_ack
);

  localparam int BEATS  = cf_beats(LINE_W, WORD_W);
  localparam int CNT_W  = cf_cnt_w(BEATS);
  localparam int OFF_W  = cf_off_w(WORD_W);
  localparam int FULL_W = BLK_LEN + CNT_W + OFF_W;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  cf_state_t          state_q;
  logic [BLK_LEN-1:0] blk_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               abort_q;
  logic               beat_we;
  logic               abort_next;

  // Byte address of a beat: block, beat index, then the in-beat byte offset,
  // fitted to the memory address width.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [BLK_LEN-1:0] blk,
                                                  input logic [CNT_W-1:0]   c);
    logic [FULL_W-1:0] full;
    full = {blk, c, {OFF_W{1'b0}}};
    return ADDR_W'(full);
  endfunction

  // A beat is taken only while a memory read is outstanding.
  assign beat_we    = (state_q == CF_S_FETCH) && m_rd && m_ack;
  // Once the cache lets go of its request, the line in flight is discarded.
  assign abort_next = abort_q || !b_rd_c;

  cmem_fill_buf #(
    .LINE_W (LINE_W),
    .WORD_W (WORD_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (beat_we),
    .idx   (cnt_q),
    .wdata (m_rdata),
    .line  (b_rdata_c)
  );

  // Fill sequencer: accept, step through the beats, then pulse data-valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CF_S_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      m_rd    <= 1'b0;
      m_addr  <= '0;
      b_dv_c  <= 1'b0;
    end else begin
      case (state_q)
        CF_S_IDLE: begin
          b_dv_c <= 1'b0;
          if (b_rd_c) begin
            blk_q   <= b_addr_c;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            m_rd    <= 1'b1;
            m_addr  <= beat_addr(b_addr_c, '0);
            state_q <= CF_S_FETCH;
          end
        end
        CF_S_FETCH: begin
          abort_q <= abort_next;
          if (beat_we) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_q <= '0;
              m_rd  <= 1'b0;
              if (abort_next) begin
                state_q <= CF_S_IDLE;
              end else begin
                b_dv_c  <= 1'b1;
                state_q <= CF_S_DONE;
              end
            end else begin
              cnt_q  <= cnt_q + 1'b1;
              m_addr <= beat_addr(blk_q, cnt_q + 1'b1);
            end
          end
        end
        CF_S_DONE: begin
          b_dv_c  <= 1'b0;
          state_q <= CF_S_IDLE;
        end
        default: begin
          b_dv_c  <= 1'b0;
          m_rd    <= 1'b0;
          state_q <= CF_S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmem_fill.sv
// Bench for the line-fill responder: a memory model with configurable ack
// delay, a table of complete fills, and hand-written abort/reset/back-to-back
// sequences.
module tb_cmem_fill;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic [57:0]   b_addr_c  = '0;
  logic          b_rd_c    = 1'b0;
  logic [511:0]  b_rdata_c;
  logic          b_dv_c;
  logic [63:0]   m_addr;
  logic          m_rd;
  logic [63:0]   m_rdata   = '0;
  logic          m_ack     = 1'b0;

  int            memDelay  = 1;
  int            waitCnt   = 0;
  int            cyc       = 0;
  int            dvCount   = 0;
  int            startCyc  = 0;
  int            latency   = 0;
  int            nCompared = 0;
  int            nMismatched = 0;
  logic [63:0]   addrLog[$];

  typedef struct {
    logic [57:0] blk;
    int          delay;
    logic [63:0] firstAddr;
    logic [63:0] lastAddr;
    int          latency;
  } vec_t;

  vec_t vecs[5];

  cmem_fill dut (
    .clk       (clk),
    .rst       (rst),
    .b_addr_c  (b_addr_c),
    .b_rd_c    (b_rd_c),
    .b_rdata_c (b_rdata_c),
    .b_dv_c    (b_dv_c),
    .m_addr    (m_addr),
    .m_rd      (m_rd),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack)
  );

  always #5 clk = ~clk;

  // Cycle number, advanced on every rising edge.
  always @(posedge clk) cyc++;

  // Memory content: word i of block b is 0x1000 + i + ((b-1) << 16).
  function automatic logic [63:0] expWord(input logic [57:0] blk, input int i);
    logic [63:0] b64;
    b64 = {6'b0, blk};
    return 64'h1000 + 64'(i) + ((b64 - 64'd1) << 16);
  endfunction

  function automatic logic [511:0] expLine(input logic [57:0] blk);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = expWord(blk, i);
    return l;
  endfunction

  // Memory model: ack each beat after memDelay cycles of m_rd, back-to-back allowed.
  always @(negedge clk) begin
    m_ack = 1'b0;
    if (!rst && m_rd) begin
      waitCnt++;
      if (waitCnt >= memDelay) begin
        m_ack   = 1'b1;
        m_rdata = expWord(m_addr[63:6], int'(m_addr[5:3]));
        waitCnt = 0;
      end
    end else begin
      waitCnt = 0;
    end
  end

  // Observer: record every requested beat address and every data-valid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_rd) addrLog.push_back(m_addr);
      if (b_dv_c) dvCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [511:0] actual,
                             input logic [511:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a request at the current falling edge and open a fresh log window.
  task automatic applyStimulus(input logic [57:0] blk, input int delay);
    memDelay = delay;
    addrLog.delete();
    dvCount  = 0;
    b_addr_c = blk;
    b_rd_c   = 1'b1;
    startCyc = cyc;
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b_dv_c) begin
        seen = 1'b1;
        break;
      end
    end
    latency = cyc - startCyc;
    b_rd_c  = 1'b0;
    if (!seen) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: no b_dv_c within 200 cycles", name);
    end
  endtask

  task automatic waitAddr(input logic [63:0] a, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_rd && m_addr == a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: m_addr %0h never requested", name, a);
    end
  endtask

  task automatic waitIdle(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!m_rd) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: m_rd stuck high", name);
    end
  endtask

  initial begin
    logic [511:0] mixed;
    logic [63:0]  lastA;
    int           bad;

    vecs[0] = '{blk: 58'h1,        delay: 1, firstAddr: 64'h40,  lastAddr: 64'h78,  latency: 9};
    vecs[1] = '{blk: 58'h1,        delay: 3, firstAddr: 64'h40,  lastAddr: 64'h78,  latency: 25};
    vecs[2] = '{blk: 58'h2A,       delay: 2, firstAddr: 64'hA80, lastAddr: 64'hAB8, latency: 17};
    vecs[3] = '{blk: {58{1'b1}},   delay: 1, firstAddr: 64'hFFFF_FFFF_FFFF_FFC0,
                lastAddr: 64'hFFFF_FFFF_FFFF_FFF8, latency: 9};
    vecs[4] = '{blk: 58'h0,        delay: 1, firstAddr: 64'h0,   lastAddr: 64'h38,  latency: 9};

    $display("[TB] start");
    #2 rst = 1'b1;
    tick(2);
    checkOutput("reset b_dv_c",    512'(b_dv_c), 512'(0));
    checkOutput("reset m_rd",      512'(m_rd),   512'(0));
    checkOutput("reset m_addr",    512'(m_addr), 512'(0));
    checkOutput("reset b_rdata_c", b_rdata_c,    512'(0));
    rst = 1'b0;
    tick(1);

    // Complete fills over several addresses and memory speeds.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].blk, vecs[v].delay);
      waitDone($sformatf("vec%0d dv", v));
      checkOutput($sformatf("vec%0d latency", v), 512'(latency), 512'(vecs[v].latency));
      checkOutput($sformatf("vec%0d line", v), b_rdata_c, expLine(vecs[v].blk));
      tick(2);
      checkOutput($sformatf("vec%0d dv pulses", v), 512'(dvCount), 512'(1));
      checkOutput($sformatf("vec%0d m_rd idle", v), 512'(m_rd), 512'(0));
      checkOutput($sformatf("vec%0d addr count", v), 512'(addrLog.size()),
                  512'(8 * vecs[v].delay));
      bad = 0;
      for (int j = 0; j < addrLog.size(); j++) begin
        if (addrLog[j] !== vecs[v].firstAddr + 64'(8 * (j / vecs[v].delay))) bad++;
      end
      checkOutput($sformatf("vec%0d addr sequence errors", v), 512'(bad), 512'(0));
      lastA = (addrLog.size() > 0) ? addrLog[addrLog.size()-1] : 64'hx;
      checkOutput($sformatf("vec%0d last addr", v), 512'(lastA), 512'(vecs[v].lastAddr));
    end

    // Reset while beat 3 is outstanding.
    applyStimulus(58'h5, 1);
    waitAddr(64'h158, "rst beat3");
    rst = 1'b1;
    #1;
    checkOutput("rst mid m_rd",   512'(m_rd),   512'(0));
    checkOutput("rst mid b_dv_c", 512'(b_dv_c), 512'(0));
    @(negedge clk);
    rst    = 1'b0;
    b_rd_c = 1'b0;
    tick(1);
    checkOutput("post rst m_rd",      512'(m_rd), 512'(0));
    checkOutput("post rst b_rdata_c", b_rdata_c,  512'(0));
    applyStimulus(58'h5, 1);
    tick(1);
    checkOutput("restart m_addr", 512'(m_addr), 512'(64'h140));
    checkOutput("restart m_rd",   512'(m_rd),   512'(1));
    waitDone("restart dv");
    checkOutput("restart latency", 512'(latency), 512'(9));
    checkOutput("restart line",    b_rdata_c,     expLine(58'h5));
    tick(1);

    // Request withdrawn after the beat-2 ack: all beats drained, no data-valid.
    applyStimulus(58'h1, 1);
    waitAddr(64'h58, "abort2 beat3");
    b_rd_c = 1'b0;
    waitIdle("abort2 drain");
    tick(2);
    checkOutput("abort2 dv pulses", 512'(dvCount), 512'(0));
    checkOutput("abort2 addr count", 512'(addrLog.size()), 512'(8));
    lastA = (addrLog.size() > 0) ? addrLog[addrLog.size()-1] : 64'hx;
    checkOutput("abort2 last addr", 512'(lastA), 512'(64'h78));
    checkOutput("abort2 line written", b_rdata_c, expLine(58'h1));
    checkOutput("abort2 m_rd idle", 512'(m_rd), 512'(0));

    // Request withdrawn together with the last ack, then a new request next cycle.
    applyStimulus(58'h1, 1);
    waitAddr(64'h78, "abortlast beat7");
    b_rd_c = 1'b0;
    tick(1);
    checkOutput("abortlast b_dv_c", 512'(b_dv_c), 512'(0));
    checkOutput("abortlast m_rd",   512'(m_rd),   512'(0));
    checkOutput("abortlast addr count", 512'(addrLog.size()), 512'(8));
    applyStimulus(58'h2, 1);
    tick(1);
    checkOutput("req2 first m_addr", 512'(m_addr), 512'(64'h80));
    checkOutput("req2 first m_rd",   512'(m_rd),   512'(1));
    waitDone("req2 dv");
    checkOutput("req2 latency", 512'(latency), 512'(9));
    checkOutput("req2 line",    b_rdata_c,     expLine(58'h2));
    tick(2);
    checkOutput("req2 dv pulses", 512'(dvCount), 512'(1));

    // Back-to-back: new request in the cycle right after data-valid.
    applyStimulus(58'h3, 1);
    waitDone("b2b line3 dv");
    tick(1);
    checkOutput("b2b line3 held", b_rdata_c, expLine(58'h3));
    applyStimulus(58'h4, 1);
    tick(1);
    checkOutput("b2b line4 first m_addr", 512'(m_addr), 512'(64'h100));
    checkOutput("b2b line4 first m_rd",   512'(m_rd),   512'(1));
    checkOutput("b2b line3 before beat0", b_rdata_c,    expLine(58'h3));
    tick(1);
    mixed = expLine(58'h3);
    mixed[63:0] = expWord(58'h4, 0);
    checkOutput("b2b after beat0", b_rdata_c, mixed);
    waitDone("b2b line4 dv");
    checkOutput("b2b line4 latency", 512'(latency), 512'(9));
    checkOutput("b2b line4 line",    b_rdata_c,     expLine(58'h4));
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
